// File: rtl/alu_pkg.sv
// Shared constants for the alu_32 / reg_file_32 datapath: widths, ALU opcodes, flag bit positions.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int FLG_W  = 3;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;

endpackage

// File: rtl/alu_flags_reg.sv
// Three-bit status register holding {overflow, carry, zero}; loads on en, synchronous active-low clear.
module alu_flags_reg
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [FLG_W-1:0] d,
    output logic [FLG_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_32.sv
// Architectural register file feeding alu_32: two async read ports, one sync write port, x0 hardwired to 0.
// Optional write-first read bypass enabled by defining REG_FILE_BYPASS_EN (default build reads old data).
module reg_file_32
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int NREGS  = alu_pkg::NREGS,
    parameter int ADDR_W = alu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              rd_we,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              flags_we,
    input  logic              zero_in,
    input  logic              carry_in,
    input  logic              ovf_in,
    output logic [2:0]        flags_q
);

    logic [DATA_W-1:0] mem [NREGS];
    logic              rs1_in_range;
    logic              rs2_in_range;
    logic              rd_in_range;
    logic              wr_en;
    logic [FLG_W-1:0]  flags_d;

    // Out-of-range addresses only exist when NREGS does not fill the address space.
    generate
        if (NREGS < (1 << ADDR_W)) begin : g_partial_space
            assign rs1_in_range = (rs1_addr < ADDR_W'(NREGS));
            assign rs2_in_range = (rs2_addr < ADDR_W'(NREGS));
            assign rd_in_range  = (rd_addr  < ADDR_W'(NREGS));
        end else begin : g_full_space
            assign rs1_in_range = 1'b1;
            assign rs2_in_range = 1'b1;
            assign rd_in_range  = 1'b1;
        end
    endgenerate

    assign wr_en = rd_we && (rd_addr != '0) && rd_in_range;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[rd_addr] <= rd_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr,
                                                    input logic              in_range);
        logic [DATA_W-1:0] val;
        val = '0;
        if (in_range && addr != '0) begin
            val = mem[addr];
`ifdef REG_FILE_BYPASS_EN
            // Write-first: a write landing this edge is forwarded to a matching reader.
            if (wr_en && rd_addr == addr) begin
                val = rd_data;
            end
`endif
        end
        return val;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr, rs1_in_range);
        rs2_data = read_port(rs2_addr, rs2_in_range);
    end

    always_comb begin
        flags_d        = '0;
        flags_d[FLG_Z] = zero_in;
        flags_d[FLG_C] = carry_in;
        flags_d[FLG_V] = ovf_in;
    end

    alu_flags_reg u_flags (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flags_we),
        .d     (flags_d),
        .q     (flags_q)
    );

endmodule

// File: tb/tb_reg_file_32.sv
// Self-checking bench for reg_file_32: array-level reference model checked every cycle plus directed literal checks.
module tb_reg_file_32;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, rd_data;
    logic        rd_we, flags_we, zero_in, carry_in, ovf_in;
    logic [2:0]  flags_q;

    int passes = 0;
    int total  = 0;

    reg_file_32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_we    (rd_we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .flags_we (flags_we),
        .zero_in  (zero_in),
        .carry_in (carry_in),
        .ovf_in   (ovf_in),
        .flags_q  (flags_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain array of register values and a flag triple.
    logic [31:0] model_regs [32];
    logic [2:0]  model_flags;
    bit          model_live = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (model_regs[i]) model_regs[i] = 32'h0;
            model_flags = 3'b000;
            model_live  = 1;
        end else begin
            if (rd_we && rd_addr != 0) model_regs[rd_addr] = rd_data;
            if (flags_we) model_flags = {ovf_in, carry_in, zero_in};
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (addr == 0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
        if (rd_we && rd_addr == addr) return rd_data;
`endif
        return model_regs[addr];
    endfunction

    always @(negedge clk) begin
        if (model_live) begin
            check("cyc_rs1", rs1_data, model_read(rs1_addr));
            check("cyc_rs2", rs2_data, model_read(rs2_addr));
            check("cyc_flags", {29'h0, flags_q}, {29'h0, model_flags});
        end
    end

    // alu_32 flag behaviour for the ops exercised here: returns {overflow, carry, zero}.
    function automatic logic [2:0] alu_flags(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] full;
        logic        v;
        if (op == ALU_SUB) begin
            full = {1'b0, a} + {1'b0, ~b} + 33'd1;
            v    = (a[31] != b[31]) && (full[31] != a[31]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            v    = (a[31] == b[31]) && (full[31] != a[31]);
        end
        return {v, full[32], full[31:0] == 32'h0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        rd_we = 1'b1; rd_addr = a; rd_data = d;
        cyc();
        rd_we = 1'b0;
    endtask

    task automatic drive_alu(input logic [3:0] op);
        logic [2:0] f;
        f = alu_flags(op, rs1_data, rs2_data);
        {ovf_in, carry_in, zero_in} = f;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, total);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rd_we = 1'b0; rd_addr = 0; rd_data = 0;
        rs1_addr = 0; rs2_addr = 0; flags_we = 0;
        zero_in = 0; carry_in = 0; ovf_in = 0;
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        check("reset_flags", {29'h0, flags_q}, 32'h0);

        // Reset clears a previously written register
        write_reg(5'd5, 32'hDEADBEEF);
        rs1_addr = 5; #1;
        check("x5_written", rs1_data, 32'hDEADBEEF);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; #1;
        check("x5_after_reset", rs1_data, 32'h0);
        check("flags_after_reset", {29'h0, flags_q}, 32'h0);

        // Basic write/read on both ports
        write_reg(5'd1, 32'd10);
        write_reg(5'd2, 32'd20);
        rs1_addr = 1; rs2_addr = 2; #1;
        check("rs1_x1", rs1_data, 32'h0000000A);
        check("rs2_x2", rs2_data, 32'h00000014);
        check("add_x1_x2", rs1_data + rs2_data, 32'h0000001E);

        // x0 protection, including same-cycle read of the target
        rd_we = 1'b1; rd_addr = 0; rd_data = 32'hFFFFFFFF;
        rs1_addr = 0; rs2_addr = 0; #1;
        check("x0_rs1_same", rs1_data, 32'h0);
        check("x0_rs2_same", rs2_data, 32'h0);
        cyc();
        rd_we = 1'b0; #1;
        check("x0_rs1_after", rs1_data, 32'h0);

        // Read-during-write
        write_reg(5'd3, 32'd7);
        rd_we = 1'b1; rd_addr = 3; rd_data = 32'd9; rs1_addr = 3; #1;
`ifdef REG_FILE_BYPASS_EN
        check("rdw_same_cycle", rs1_data, 32'd9);
`else
        check("rdw_same_cycle", rs1_data, 32'd7);
`endif
        cyc();
        rd_we = 1'b0; #1;
        check("rdw_next_cycle", rs1_data, 32'd9);

        // Top register, both ports on the same address
        write_reg(5'd31, 32'hA5A5_0F0F);
        rs1_addr = 31; rs2_addr = 31; #1;
        check("x31_rs1", rs1_data, 32'hA5A5_0F0F);
        check("x31_rs2", rs2_data, 32'hA5A5_0F0F);

        // Flags capture and hold
        write_reg(5'd4, 32'h7FFFFFFF);
        write_reg(5'd6, 32'h00000001);
        rs1_addr = 4; rs2_addr = 6; #1;
        drive_alu(ALU_ADD);
        flags_we = 1'b1;
        cyc();
        flags_we = 1'b0; #1;
        check("flags_add_ovf", {29'h0, flags_q}, 32'h4);
        rs1_addr = 1; rs2_addr = 1; #1;
        drive_alu(ALU_SUB);
        flags_we = 1'b1;
        cyc();
        flags_we = 1'b0;
        {ovf_in, carry_in, zero_in} = 3'b111; #1;
        check("flags_sub_zero", {29'h0, flags_q}, 32'h3);
        cyc(); cyc();
        check("flags_hold", {29'h0, flags_q}, 32'h3);

        // Reset dominates simultaneous write and flag capture
        rst_n = 1'b0; rd_we = 1'b1; rd_addr = 7; rd_data = 32'h55;
        flags_we = 1'b1; {ovf_in, carry_in, zero_in} = 3'b111;
        cyc();
        rst_n = 1'b1; rd_we = 1'b0; flags_we = 1'b0;
        rs1_addr = 7; rs2_addr = 1; #1;
        check("x7_reset_priority", rs1_data, 32'h0);
        check("x1_cleared", rs2_data, 32'h0);
        check("flags_reset_priority", {29'h0, flags_q}, 32'h0);
        cyc(); cyc();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
